// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin AXI-Stream arbiter.
package axis_pkg;

  // Default master/source data width.
  localparam int AXIS_DATA_W = 32;

  // Arbiter FSM encoding.
  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_t;

  // Index of the set bit of a one-hot vector (up to 16 sources).
  // An all-zero input returns 0; only called while a grant is held.
  function automatic int onehot2idx(input logic [15:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// Bundle of the per-source slave streams and the shared master stream.
// The slave modport is the arbiter's view; master is the producer/sink side.
interface axis_rr_arbiter_if
  import axis_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = AXIS_DATA_W
);

  logic [NUM_SRC-1:0]        s_tvalid;
  logic [NUM_SRC*DATA_W-1:0] s_tdata;
  logic [NUM_SRC-1:0]        s_tlast;
  logic [NUM_SRC-1:0]        s_tready;

  logic                      m_tvalid;
  logic [DATA_W-1:0]         m_tdata;
  logic                      m_tlast;
  logic                      m_tready;

  modport slave (
    input  s_tvalid, s_tdata, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast
  );

  modport master (
    output s_tvalid, s_tdata, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast
  );

endinterface

// File: rtl/axis_rr_arbiter_pick.sv
// Rotating-priority selector: first set request at or above ptr_i,
// wrapping from NUM_SRC-1 back to 0. Purely combinational.
module axis_rr_pick
  import axis_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] pick_o
);

  // Scan NUM_SRC positions starting at the pointer; the first hit wins.
  always_comb begin
    int  idx;
    logic found;
    pick_o = '0;
    found  = 1'b0;
    idx    = 0;
    for (int off = 0; off < NUM_SRC; off++) begin
      idx = (int'(ptr_i) + off) % NUM_SRC;
      if (!found && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream master link
// between NUM_SRC sources. A grant is held from the first beat to the
// tlast handshake, so packets are never interleaved.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no grant; outputs quiet; arbitrate among tvalid requests
//   PASS  | granted source passed straight through to the master port
//
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = AXIS_DATA_W,
  parameter int CNT_W   = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  axis_rr_arbiter_if.slave     bus,
  output logic [NUM_SRC-1:0]   grant,
  output logic                 busy,
  output logic                 pkt_done,
  output logic [CNT_W-1:0]     pkt_cnt
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic ST_IDLE = 1'(IDLE);
  localparam logic ST_PASS = 1'(PASS);

  logic                state_q, state_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;

  logic [NUM_SRC-1:0]  pick;
  logic                g_valid;
  logic                g_last;
  logic [DATA_W-1:0]   g_data;
  logic                in_pass;
  logic                hs;
  logic                pkt_end;
  logic [PTR_W-1:0]    ptr_next;

  axis_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i   (bus.s_tvalid),
    .ptr_i   (ptr_q),
    .pick_o  (pick)
  );

  // Select the granted source's valid/data/last with a one-hot AND-OR mux.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) begin
        g_valid = g_valid | bus.s_tvalid[i];
        g_last  = g_last  | bus.s_tlast[i];
        g_data  = g_data  | bus.s_tdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Zero-latency pass-through while a packet is in flight; quiet in IDLE.
  assign in_pass      = (state_q == ST_PASS);
  assign bus.m_tvalid = in_pass & g_valid;
  assign bus.m_tlast  = in_pass & g_last;
  assign bus.m_tdata  = in_pass ? g_data : '0;
  assign bus.s_tready = in_pass ? (grant_q & {NUM_SRC{bus.m_tready}}) : '0;

  assign hs      = bus.m_tvalid & bus.m_tready;
  assign pkt_end = hs & bus.m_tlast;

  // The source just served drops to lowest priority for the next round.
  assign ptr_next = PTR_W'((onehot2idx(16'(grant_q)) + 1) % NUM_SRC);

  // Next-state logic: grant on any request in IDLE, release on tlast handshake.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.s_tvalid) begin
          grant_d = pick;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        if (pkt_end) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
          cnt_d   = cnt_q + 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, grant, pointer and packet counter registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = in_pass;
  assign pkt_done = done_q;
  assign pkt_cnt  = cnt_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: behavioural model of the
// packet-level round-robin rules, compared against the DUT every cycle.
module tb_axis_rr_arbiter;
  import axis_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic [N-1:0]  grant;
  logic          busy;
  logic          pkt_done;
  logic [CW-1:0] pkt_cnt;

  axis_rr_arbiter_if #(.NUM_SRC(N), .DATA_W(DW)) ifc ();

  axis_rr_arbiter #(.NUM_SRC(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .bus      (ifc),
    .grant    (grant),
    .busy     (busy),
    .pkt_done (pkt_done),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [7:0]    gap;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t srcq [N][$];
  int    wait_cnt [N];
  bit    armed [N];
  int    offer_cyc [N];
  int    vprob, rprob;
  bit    rdy_pat [$];

  // model: busy flag, granted index, pointer, packet count, done pulse
  bit mb;
  int mg, mptr, mcnt;
  bit mdone;

  int            cyc;
  int            hs_src [$];
  logic [DW-1:0] hs_data [$];
  int            hs_cyc [$];
  int            grant_log [$];
  int            done_cnt_log [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic push(input int s, input logic [DW-1:0] d, input bit last, input int gap);
    beat_t b;
    b.gap  = 8'(gap);
    b.last = last;
    b.data = d;
    srcq[s].push_back(b);
  endtask

  task automatic zero_inputs();
    ifc.s_tvalid = '0;
    ifc.s_tdata  = '0;
    ifc.s_tlast  = '0;
    ifc.m_tready = 1'b0;
  endtask

  task automatic model_reset();
    mb = 1'b0; mg = 0; mptr = 0; mcnt = 0; mdone = 1'b0;
  endtask

  task automatic clear_tb();
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      armed[i]     = 1'b0;
      wait_cnt[i]  = 0;
      offer_cyc[i] = -1;
    end
    rdy_pat.delete();
    hs_src.delete(); hs_data.delete(); hs_cyc.delete();
    grant_log.delete(); done_cnt_log.delete();
    vprob = 100; rprob = 100;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      ifc.s_tdata[i*DW +: DW] = $urandom;
      ifc.s_tlast[i]          = 1'($urandom_range(1));
      ifc.s_tvalid[i]         = 1'b0;
      if (srcq[i].size() > 0) begin
        if (!armed[i]) begin
          wait_cnt[i] = int'(srcq[i][0].gap);
          armed[i]    = 1'b1;
        end
        if (wait_cnt[i] > 0) begin
          wait_cnt[i]--;
        end else if ($urandom_range(99) < vprob) begin
          ifc.s_tvalid[i]         = 1'b1;
          ifc.s_tdata[i*DW +: DW] = srcq[i][0].data;
          ifc.s_tlast[i]          = srcq[i][0].last;
          if (offer_cyc[i] < 0) offer_cyc[i] = cyc;
        end
      end
    end
    if (mb && rdy_pat.size() > 0) ifc.m_tready = rdy_pat.pop_front();
    else                          ifc.m_tready = ($urandom_range(99) < rprob);
  endtask

  task automatic compare();
    logic [N-1:0]  eg, er;
    logic          ev, el;
    logic [DW-1:0] ed;
    eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0;
    if (mb) begin
      eg[mg] = 1'b1;
      er[mg] = ifc.m_tready;
      ev     = ifc.s_tvalid[mg];
      ed     = ifc.s_tdata[mg*DW +: DW];
      el     = ifc.s_tlast[mg];
    end
    chk("grant",    64'(grant),        64'(eg));
    chk("s_tready", 64'(ifc.s_tready), 64'(er));
    chk("m_tvalid", 64'(ifc.m_tvalid), 64'(ev));
    chk("m_tdata",  64'(ifc.m_tdata),  64'(ed));
    chk("m_tlast",  64'(ifc.m_tlast),  64'(el));
    chk("busy",     64'(busy),         64'(mb));
    chk("pkt_done", 64'(pkt_done),     64'(mdone));
    chk("pkt_cnt",  64'(pkt_cnt),      64'(mcnt % (1 << CW)));
    if (pkt_done === 1'b1) done_cnt_log.push_back(int'(pkt_cnt));
  endtask

  // Model step at the rising edge; inputs are stable here.
  task automatic update();
    int j;
    if (areset) begin
      model_reset();
      return;
    end
    mdone = 1'b0;
    if (!mb) begin
      for (int k = 0; k < N; k++) begin
        j = (mptr + k) % N;
        if (ifc.s_tvalid[j]) begin
          mb = 1'b1;
          mg = j;
          grant_log.push_back(j);
          break;
        end
      end
    end else if (ifc.s_tvalid[mg] && ifc.m_tready) begin
      hs_src.push_back(mg);
      hs_data.push_back(ifc.s_tdata[mg*DW +: DW]);
      hs_cyc.push_back(cyc);
      void'(srcq[mg].pop_front());
      armed[mg] = 1'b0;
      if (ifc.s_tlast[mg]) begin
        mb    = 1'b0;
        mptr  = (mg + 1) % N;
        mcnt  = mcnt + 1;
        mdone = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge aclk);
    cyc++;
    drive();
    #1 compare();
    @(posedge aclk);
    update();
  endtask

  task automatic run(input int maxc);
    int n;
    n = 0;
    while ((pending() || mb) && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 64'(pending() || mb), 64'(0));
    cycle();
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    zero_inputs();
    clear_tb();
    model_reset();
    #1 compare();
    @(negedge aclk);
    areset = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s, len;
    areset = 1'b1;
    zero_inputs();
    clear_tb();
    model_reset();
    cyc = 0;
    repeat (2) @(negedge aclk);

    // reset state
    #1;
    chk("rst_grant",  64'(grant),        64'(0));
    chk("rst_tready", 64'(ifc.s_tready), 64'(0));
    chk("rst_mvalid", 64'(ifc.m_tvalid), 64'(0));
    chk("rst_cnt",    64'(pkt_cnt),      64'(0));

    // single source, three beats
    do_reset();
    push(2, 32'hAAAA_BBBB, 1'b0, 0);
    push(2, 32'hAAAA_BBBC, 1'b0, 0);
    push(2, 32'hAAAA_BBBD, 1'b1, 0);
    run(50);
    chk("t1_nbeats", 64'(hs_data.size()), 64'(3));
    chk("t1_d0", 64'(hs_data[0]), 64'h0000_0000_AAAA_BBBB);
    chk("t1_d1", 64'(hs_data[1]), 64'h0000_0000_AAAA_BBBC);
    chk("t1_d2", 64'(hs_data[2]), 64'h0000_0000_AAAA_BBBD);
    chk("t1_grant_src", 64'(grant_log[0]), 64'(2));
    chk("t1_latency", 64'(hs_cyc[0] - offer_cyc[2]), 64'(1));
    chk("t1_consec", 64'(hs_cyc[2] - hs_cyc[0]), 64'(2));
    chk("t1_cnt", 64'(pkt_cnt), 64'(1));

    // contention: all four sources with 2-beat packets
    do_reset();
    for (int i = 0; i < N; i++) begin
      push(i, 32'h1000_0000 * (i + 1),     1'b0, 0);
      push(i, 32'h1000_0000 * (i + 1) + 1, 1'b1, 0);
    end
    run(100);
    for (int i = 0; i < N; i++) begin
      chk("t2_order", 64'(grant_log[i]), 64'(i));
      chk("t2_noint", 64'(hs_src[2*i+1]), 64'(i));
    end
    chk("t2_bubble", 64'(hs_cyc[2] - hs_cyc[1]), 64'(2));
    chk("t2_cnt", 64'(pkt_cnt), 64'(4));

    // backpressure on source 1
    do_reset();
    rdy_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    push(1, 32'hCCCC_DDDD, 1'b0, 0);
    push(1, 32'hCCCC_DDDE, 1'b1, 0);
    run(50);
    chk("t3_nbeats", 64'(hs_data.size()), 64'(2));
    chk("t3_d0", 64'(hs_data[0]), 64'h0000_0000_CCCC_DDDD);
    chk("t3_d1", 64'(hs_data[1]), 64'h0000_0000_CCCC_DDDE);
    chk("t3_gap", 64'(hs_cyc[1] - hs_cyc[0]), 64'(3));
    chk("t3_cnt", 64'(pkt_cnt), 64'(1));

    // tvalid gap on source 0 while source 3 waits
    do_reset();
    push(0, 32'h0A0A_0001, 1'b0, 0);
    push(0, 32'h0A0A_0002, 1'b1, 3);
    push(3, 32'h0303_0001, 1'b1, 0);
    run(50);
    chk("t4_first", 64'(grant_log[0]), 64'(0));
    chk("t4_second", 64'(grant_log[1]), 64'(3));
    chk("t4_hold", 64'(hs_cyc[1] - hs_cyc[0]), 64'(4));
    chk("t4_src3", 64'(hs_src[2]), 64'(3));

    // asynchronous reset in the middle of a packet
    do_reset();
    push(3, 32'h3333_0001, 1'b1, 0);
    run(50);
    for (int b = 0; b < 4; b++) push(1, 32'h1111_0000 + b, (b == 3), 0);
    n = 0;
    while (hs_data.size() < 3 && n < 50) begin
      cycle();
      n++;
    end
    chk("t5_reach", 64'(hs_data.size()), 64'(3));
    @(negedge aclk);
    cyc++;
    drive();
    #1 compare();
    #1 areset = 1'b1;
    #1;
    chk("t5_grant",  64'(grant),        64'(0));
    chk("t5_tready", 64'(ifc.s_tready), 64'(0));
    chk("t5_mvalid", 64'(ifc.m_tvalid), 64'(0));
    chk("t5_mdata",  64'(ifc.m_tdata),  64'(0));
    chk("t5_mlast",  64'(ifc.m_tlast),  64'(0));
    chk("t5_busy",   64'(busy),         64'(0));
    chk("t5_done",   64'(pkt_done),     64'(0));
    chk("t5_cnt",    64'(pkt_cnt),      64'(0));
    zero_inputs();
    clear_tb();
    model_reset();
    push(3, 32'h3333_0002, 1'b1, 0);
    push(2, 32'h2222_0001, 1'b1, 0);
    @(negedge aclk);
    areset = 1'b0;
    run(50);
    chk("t5_regrant0", 64'(grant_log[0]), 64'(2));
    chk("t5_regrant1", 64'(grant_log[1]), 64'(3));
    chk("t5_cnt_after", 64'(pkt_cnt), 64'(2));

    // counter wrap with a 4-bit counter
    do_reset();
    for (int p = 0; p < 17; p++) push(p % N, 32'h5000_0000 + p, 1'b1, 0);
    run(300);
    chk("t6_ndone", 64'(done_cnt_log.size()), 64'(17));
    chk("t6_c15", 64'(done_cnt_log[14]), 64'(15));
    chk("t6_c16", 64'(done_cnt_log[15]), 64'(0));
    chk("t6_c17", 64'(done_cnt_log[16]), 64'(1));

    // randomized traffic
    do_reset();
    vprob = 70;
    rprob = 60;
    for (int p = 0; p < 120; p++) begin
      s   = $urandom_range(N - 1);
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++)
        push(s, $urandom, (b == len - 1),
             ($urandom_range(9) == 0) ? $urandom_range(1, 3) : 0);
    end
    run(20000);
    chk("t7_pkts", 64'(mcnt), 64'(120));
    chk("t7_cnt", 64'(pkt_cnt), 64'(120 % (1 << CW)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
